cla_pipe_adder: RTL and testbench

CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

---
 rtl/cla_pkg.sv | 48 ++++
 rtl/cla_slice.sv | 71 +++++++
 rtl/cla_pipe_adder.sv | 122 ++++++++++++
 tb/tb_cla_pipe_adder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// cla_pkg: shared defaults and 4-bit lookahead
// helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 8;
  localparam int GRP       = 4;

  // group generate as a flat sum of products
  function automatic logic grp_gen(
    input logic [GRP-1:0] g,
    input logic [GRP-1:0] p
  );
    logic acc;
    logic pp;
    acc = 1'b0;
    pp  = 1'b1;
    for (int m = GRP - 1; m >= 0; m--) begin
      acc = acc | (pp & g[m]);
      pp  = pp & p[m];
    end
    return acc;
  endfunction

  // carry into each bit of a group, flat sum of
  // products from the group carry-in
  function automatic logic [GRP-1:0] grp_carry(
    input logic [GRP-2:0] g,
    input logic [GRP-2:0] p,
    input logic           ci
  );
    logic [GRP-1:0] c;
    logic           acc;
    logic           pp;
    c = '0;
    for (int i = 0; i < GRP; i++) begin
      acc = 1'b0;
      pp  = 1'b1;
      for (int m = i - 1; m >= 0; m--) begin
        acc = acc | (pp & g[m]);
        pp  = pp & p[m];
      end
      c[i] = acc | (pp & ci);
    end
    return c;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// cla_slice: combinational N-bit adder built from
// 4-bit lookahead groups with group lookahead.
module cla_slice
  import cla_pkg::*;
#(
  parameter int N = DEF_SLICE
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         cmsb
);

  localparam int NG = N / GRP;

  logic [N-1:0]  g;
  logic [N-1:0]  p;
  logic [N-1:0]  c;
  logic [NG-1:0] gg;
  logic [NG-1:0] gp;
  logic [NG:0]   gc;

  assign g = a & b;
  assign p = a ^ b;

  // per-group generate and propagate
  always_comb begin
    gg = '0;
    gp = '0;
    for (int j = 0; j < NG; j++) begin
      gg[j] = grp_gen(g[j*GRP +: GRP], p[j*GRP +: GRP]);
      gp[j] = &p[j*GRP +: GRP];
    end
  end

  // group carries straight from cin, no chaining
  always_comb begin
    logic acc;
    logic pp;
    gc  = '0;
    acc = 1'b0;
    pp  = 1'b1;
    for (int j = 0; j <= NG; j++) begin
      acc = 1'b0;
      pp  = 1'b1;
      for (int m = j - 1; m >= 0; m--) begin
        acc = acc | (pp & gg[m]);
        pp  = pp & gp[m];
      end
      gc[j] = acc | (pp & cin);
    end
  end

  // bit carries inside each group
  always_comb begin
    c = '0;
    for (int j = 0; j < NG; j++) begin
      c[j*GRP +: GRP] = grp_carry(
        g[j*GRP +: GRP-1],
        p[j*GRP +: GRP-1],
        gc[j]);
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[NG];
  assign cmsb = c[N-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: add/sub pipelined one slice per
// stage; upper operand slices ride along as skew.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTG = WIDTH / SLICE;

  if (WIDTH < 8 || WIDTH > 64 || SLICE < GRP ||
      SLICE % GRP != 0 || WIDTH % SLICE != 0)
  begin : g_bad
    $fatal(1, "cla_pipe_adder: illegal WIDTH/SLICE");
  end

  logic [WIDTH-1:0] eb;
  logic             ec;
  logic             en;

  assign eb       = sub ? ~b : b;
  assign ec       = sub | cin;
  assign en       = !out_valid || out_ready;
  assign in_ready = !rst_n || en;

  // ra rotates: consumed A slices leave the bottom,
  // finished sum slices enter the top
  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int IN = WIDTH - k * SLICE;

    logic [WIDTH-1:0] xa;
    logic [IN-1:0]    xb;
    logic             xc;
    logic             xv;
    logic [SLICE-1:0] s;
    logic             co;
    logic             cm;
    logic             rv;
    logic             rc;
    logic [WIDTH-1:0] ra;

    if (k == 0) begin : g_src
      assign xa = a;
      assign xb = eb;
      assign xc = ec;
      assign xv = in_valid;
    end else begin : g_src
      assign xa = g_stg[k-1].ra;
      assign xb = g_stg[k-1].g_mid.rb;
      assign xc = g_stg[k-1].rc;
      assign xv = g_stg[k-1].rv;
    end

    cla_slice #(
      .N(SLICE)
    ) u_slice (
      .a    (xa[SLICE-1:0]),
      .b    (xb[SLICE-1:0]),
      .cin  (xc),
      .sum  (s),
      .cout (co),
      .cmsb (cm)
    );

    // stage valid bit, cleared by reset
    always_ff @(posedge clk) begin
      if (!rst_n) rv <= 1'b0;
      else if (en) rv <= xv;
    end

    if (k < NSTG - 1) begin : g_mid
      logic [IN-SLICE-1:0] rb;
      logic                unused_cm;
      assign unused_cm = cm;

      // skewed operands and slice carry, no reset
      always_ff @(posedge clk) begin
        if (en) begin
          rb <= xb[IN-1:SLICE];
          ra <= WIDTH'({s, xa} >> SLICE);
          rc <= co;
        end
      end
    end else begin : g_last
      logic ro;

      // result registers, held while stalled
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ra <= '0;
          rc <= 1'b0;
          ro <= 1'b0;
        end else if (en) begin
          ra <= WIDTH'({s, xa} >> SLICE);
          rc <= co;
          ro <= cm ^ co;
        end
      end
    end
  end

  assign out_valid = g_stg[NSTG-1].rv;
  assign sum       = g_stg[NSTG-1].ra;
  assign cout      = g_stg[NSTG-1].rc;
  assign ovf       = g_stg[NSTG-1].g_last.ro;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: vector table, stall/reset
// sequences and a random scoreboard sweep.
module tb_cla_pipe_adder;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  int n_in   = 0;
  int n_out  = 0;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  res_t sb[$];
  logic hold_v = 1'b0;
  res_t hold_r;
  vec_t vecs[7];

  cla_pipe_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  function automatic res_t model(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         ci,
    input logic         s
  );
    longint u;
    longint sv;
    res_t   r;
    if (s) begin
      u      = longint'(x) - longint'(y);
      sv     = longint'($signed(x)) - longint'($signed(y));
      r.cout = (x >= y);
    end else begin
      u      = longint'(x) + longint'(y) + longint'(ci);
      sv     = longint'($signed(x)) + longint'($signed(y))
             + longint'(ci);
      r.cout = (u >= 64'sh1_0000_0000);
    end
    r.sum = u[W-1:0];
    r.ovf = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
    return r;
  endfunction

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard: acceptance order, output order, stability
  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      sb.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_sum", sum, hold_r.sum);
        chk("hold_cout", cout, hold_r.cout);
        chk("hold_ovf", ovf, hold_r.ovf);
      end
      if (out_valid && out_ready) begin
        chk("result_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          n_out++;
          chk("out_sum", sum, e.sum);
          chk("out_cout", cout, e.cout);
          chk("out_ovf", ovf, e.ovf);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(a, b, cin, sub));
        n_in++;
      end
      hold_v = out_valid && !out_ready;
      hold_r = {sum, cout, ovf};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_op();
    a   = $urandom;
    b   = $urandom;
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF;
    if ($urandom_range(0, 7) == 0) b = 32'h8000_0000;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a   = v.a;
    b   = v.b;
    cin = v.cin;
    sub = v.sub;
    step();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({name, "_latency"}, n, 4);
    chk({name, "_sum"}, sum, v.sum);
    chk({name, "_cout"}, cout, v.cout);
    chk({name, "_ovf"}, ovf, v.ovf);
    step();
  endtask

  task automatic backpressure();
    int   sent;
    int   c;
    int   base;
    logic acc;
    logic have;
    base = n_out;
    sent = 0;
    c    = 0;
    have = 1'b0;
    while (sent < 10 && c < 100) begin
      if (!have) begin
        rand_op();
        have = 1'b1;
      end
      in_valid  = 1'b1;
      out_ready = !(c >= 6 && c <= 8);
      @(negedge clk);
      if (!out_ready) chk("bp_in_ready", in_ready, 0);
      acc = in_ready;
      step();
      c++;
      if (acc) begin
        sent++;
        have = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    c = 0;
    while (n_out - base < 10 && c < 30) begin
      step();
      c++;
    end
    repeat (6) step();
    chk("bp_count", n_out - base, 10);
    chk("bp_queue", sb.size(), 0);
  endtask

  task automatic reset_mid();
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      rand_op();
      step();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    chk("rst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    n = 0;
    repeat (8) begin
      step();
      if (out_valid) n++;
    end
    chk("rst_no_stale", n, 0);
    run_vec(vecs[1], "post_rst");
  endtask

  task automatic sweep(input int nops);
    int   sent;
    int   c;
    int   in0;
    int   out0;
    logic acc;
    logic have;
    in0  = n_in;
    out0 = n_out;
    sent = 0;
    c    = 0;
    have = 1'b0;
    while (sent < nops && c < 60000) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        rand_op();
        have = 1'b1;
      end
      in_valid  = have;
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      step();
      c++;
      if (acc) begin
        sent++;
        have = 1'b0;
      end
    end
    chk("sweep_sent", sent, nops);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    c = 0;
    while (sb.size() != 0 && c < 50) begin
      step();
      c++;
    end
    chk("sweep_count", n_out - out0, n_in - in0);
    chk("sweep_queue", sb.size(), 0);
  endtask

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                32'h8000_0000, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1,
                32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1,
                32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0,
                32'h0000_0001, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1,
                32'h0000_0007, 1'b1, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0,
                32'h0000_0000, 1'b1, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a   = '0;
    b   = '0;
    cin = 1'b0;
    sub = 1'b0;
    step();
    step();
    chk("rst_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    backpressure();
    reset_mid();
    sweep(10000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
